// File: rtl/cs_num_gen.sv
// Active-device counter and ADC/Ethernet length calculator for the command/status path.
// Latches the device mask and mode on fs, counts serially, then derives saturated lengths.
module cs_num_gen #(
  parameter int N_DEV      = 8,
  parameter int RX_W       = 10,
  parameter int TX_W       = 12,
  parameter int RX_PER_DEV = 96,
  parameter int RX_HEAD    = 4,
  parameter int TX_HEAD    = 16,
  localparam int CW        = $clog2(N_DEV + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_DEV-1:0] cmd_kdev,
  input  logic [1:0]       cmd_mode,
  input  logic             fs,
  output logic             fd,
  output logic [RX_W-1:0]  adc_rx_len,
  output logic [TX_W-1:0]  eth_tx_len,
  output logic [CW-1:0]    dev_cnt,
  output logic             err
);

  localparam int IW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
  // Wide enough that count*RX_PER_DEV shifted by 2 plus a header can never wrap.
  localparam int PW = ((TX_W > RX_W) ? TX_W : RX_W) + CW + 36;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    CALC,
    TXC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [N_DEV-1:0] mask_q, mask_d;
  logic [1:0]       mode_q, mode_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             fd_q, fd_d;
  logic [RX_W-1:0]  adc_q, adc_d;
  logic [TX_W-1:0]  eth_q, eth_d;
  logic [CW-1:0]    dcnt_q, dcnt_d;
  logic             err_q, err_d;

  logic [PW-1:0]    payload;
  logic [PW-1:0]    rx_sum;
  logic [PW-1:0]    tx_sum;
  logic [1:0]       eff_mode;
  logic             rx_sat;
  logic             tx_sat;

  always_comb begin
    payload  = PW'(cnt_q) * PW'(RX_PER_DEV);
    rx_sum   = payload + PW'(RX_HEAD);
    eff_mode = (mode_q == 2'd3) ? 2'd2 : mode_q;
    tx_sum   = (payload << eff_mode) + PW'(TX_HEAD);
    rx_sat   = (rx_sum > PW'({RX_W{1'b1}}));
    tx_sat   = (tx_sum > PW'({TX_W{1'b1}}));

    state_d = state_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    fd_d    = fd_q;
    adc_d   = adc_q;
    eth_d   = eth_q;
    dcnt_d  = dcnt_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (fs) begin
          mask_d  = cmd_kdev;
          mode_d  = cmd_mode;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + CW'(mask_q[idx_q]);
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(N_DEV - 1)) state_d = CALC;
      end
      CALC: begin
        adc_d   = rx_sat ? '1 : rx_sum[RX_W-1:0];
        sat_d   = rx_sat;
        dcnt_d  = cnt_q;
        state_d = TXC;
      end
      TXC: begin
        eth_d   = tx_sat ? '1 : tx_sum[TX_W-1:0];
        err_d   = sat_q | tx_sat | (mode_q == 2'd3);
        fd_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!fs) begin
          fd_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      mode_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      fd_q    <= 1'b0;
      adc_q   <= '0;
      eth_q   <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      fd_q    <= fd_d;
      adc_q   <= adc_d;
      eth_q   <= eth_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
    end
  end

  assign fd         = fd_q;
  assign adc_rx_len = adc_q;
  assign eth_tx_len = eth_q;
  assign dev_cnt    = dcnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cs_num_gen.sv
// Bench for cs_num_gen: default instance plus a TX_W=11 instance sharing the same stimulus.
module tb_cs_num_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cmd_kdev;
  logic [1:0] cmd_mode;
  logic       fs;

  logic        fd, fd11;
  logic [9:0]  adc, adc11;
  logic [11:0] eth;
  logic [10:0] eth11;
  logic [3:0]  cnt, cnt11;
  logic        err, err11;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cs_num_gen dut (
    .clk(clk), .rst_n(rst_n), .cmd_kdev(cmd_kdev), .cmd_mode(cmd_mode), .fs(fs),
    .fd(fd), .adc_rx_len(adc), .eth_tx_len(eth), .dev_cnt(cnt), .err(err)
  );

  cs_num_gen #(.TX_W(11)) dut11 (
    .clk(clk), .rst_n(rst_n), .cmd_kdev(cmd_kdev), .cmd_mode(cmd_mode), .fs(fs),
    .fd(fd11), .adc_rx_len(adc11), .eth_tx_len(eth11), .dev_cnt(cnt11), .err(err11)
  );

  typedef struct {
    logic [7:0] kdev;
    logic [1:0] mode;
    int cnt, adc, eth, err, eth11, err11;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: popcount, then plain arithmetic with clamping.
  function automatic vec_t model(input logic [7:0] k, input logic [1:0] m);
    vec_t   v;
    longint p, a, e, e11;
    int     sh;
    bit     rs;
    v.kdev = k;
    v.mode = m;
    v.cnt  = 0;
    for (int i = 0; i < 8; i++) if (k[i]) v.cnt++;
    p  = v.cnt * 96;
    a  = p + 4;
    rs = (a > 1023);
    if (rs) a = 1023;
    sh  = (m == 3) ? 2 : int'(m);
    e   = p * (1 << sh) + 16;
    e11 = e;
    v.err   = (rs || e > 4095 || m == 3) ? 1 : 0;
    v.err11 = (rs || e11 > 2047 || m == 3) ? 1 : 0;
    if (e > 4095) e = 4095;
    if (e11 > 2047) e11 = 2047;
    v.adc   = int'(a);
    v.eth   = int'(e);
    v.eth11 = int'(e11);
    return v;
  endfunction

  task automatic check_res(input string tag, input vec_t v);
    chk({tag, ".dev_cnt"}, cnt, v.cnt);
    chk({tag, ".adc_rx_len"}, adc, v.adc);
    chk({tag, ".eth_tx_len"}, eth, v.eth);
    chk({tag, ".err"}, err, v.err);
    chk({tag, ".tx11.dev_cnt"}, cnt11, v.cnt);
    chk({tag, ".tx11.adc_rx_len"}, adc11, v.adc);
    chk({tag, ".tx11.eth_tx_len"}, eth11, v.eth11);
    chk({tag, ".tx11.err"}, err11, v.err11);
  endtask

  // One request; inputs are scrambled right after the latch edge to prove they are ignored.
  task automatic do_req(input string tag, input vec_t v, input bit pulse);
    int lat;
    cmd_kdev = v.kdev;
    cmd_mode = v.mode;
    fs = 1'b1;
    @(posedge clk); #1;
    cmd_kdev = ~v.kdev;
    cmd_mode = ~v.mode;
    if (pulse) fs = 1'b0;
    lat = 0;
    while (!fd && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, 10);
    chk({tag, ".fd11"}, fd11, 1);
    check_res(tag, v);
    if (!pulse) begin
      repeat (3) @(posedge clk);
      #1;
      chk({tag, ".fd_hold"}, fd, 1);
      fs = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, ".fd_drop"}, fd, 0);
    check_res({tag, ".idle_hold"}, v);
  endtask

  vec_t tbl[6];
  vec_t rv;
  int   seen;

  initial begin
    tbl[0] = '{kdev: 8'hFF, mode: 2'd0, cnt: 8, adc: 772, eth: 784,  err: 0, eth11: 784,  err11: 0};
    tbl[1] = '{kdev: 8'h05, mode: 2'd1, cnt: 2, adc: 196, eth: 400,  err: 0, eth11: 400,  err11: 0};
    tbl[2] = '{kdev: 8'h00, mode: 2'd0, cnt: 0, adc: 4,   eth: 16,   err: 0, eth11: 16,   err11: 0};
    tbl[3] = '{kdev: 8'hFF, mode: 2'd2, cnt: 8, adc: 772, eth: 3088, err: 0, eth11: 2047, err11: 1};
    tbl[4] = '{kdev: 8'h0F, mode: 2'd3, cnt: 4, adc: 388, eth: 1552, err: 1, eth11: 1552, err11: 1};
    tbl[5] = '{kdev: 8'h03, mode: 2'd0, cnt: 2, adc: 196, eth: 208,  err: 0, eth11: 208,  err11: 0};

    rst_n = 1'b0;
    fs = 1'b0;
    cmd_kdev = '0;
    cmd_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.fd", fd, 0);
    chk("reset.adc", adc, 0);
    chk("reset.eth", eth, 0);
    chk("reset.cnt", cnt, 0);
    chk("reset.err", err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      do_req($sformatf("vec%0d", i), tbl[i], (i == 5));

    // Reset pulse with SCAN at index 4: outputs clear immediately and no fd follows.
    cmd_kdev = 8'hFF;
    cmd_mode = 2'd0;
    fs = 1'b1;
    @(posedge clk); #1;
    fs = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.fd", fd, 0);
    chk("midrst.adc", adc, 0);
    chk("midrst.eth", eth, 0);
    chk("midrst.cnt", cnt, 0);
    chk("midrst.err", err, 0);
    chk("midrst.eth11", eth11, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (fd || fd11) seen = 1;
    end
    chk("midrst.no_fd", seen, 0);
    do_req("after_rst", tbl[4], 1'b0);

    for (int i = 0; i < 25; i++) begin
      rv = model(8'($urandom), 2'($urandom_range(0, 3)));
      do_req($sformatf("rnd%0d", i), rv, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cs_num_gen.md
Name: cs_num_gen

Overview:
Parametrised successor to the device-count/length calculator in the command/status path. It latches a device-present mask and an aggregation mode on an fs/fd handshake and counts active devices serially. It then derives the ADC receive length and the Ethernet transmit length, with saturation and an error flag. It sits between the command decoder (cmd_kdev, cmd_mode) and the ADC/ETH framers, which consume the lengths when fd is high.

Parameters:
N_DEV, 8, number of device-present bits in cmd_kdev (>=1)
RX_W, 10, width of adc_rx_len
TX_W, 12, width of eth_tx_len
RX_PER_DEV, 96, ADC payload bytes per active device
RX_HEAD, 4, ADC frame header bytes
TX_HEAD, 16, Ethernet header bytes
(localparam CW = $clog2(N_DEV+1), width of dev_cnt)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_kdev  in  N_DEV  device-present mask, bit i = device i active
cmd_mode  in  2  aggregation: 0=1 frame, 1=2 frames, 2=4 frames, 3=reserved
fs  in  1  start request, level
fd  out  1  done, registered
adc_rx_len  out  RX_W  ADC receive length in bytes
eth_tx_len  out  TX_W  Ethernet transmit length in bytes
dev_cnt  out  CW  number of active devices
err  out  1  reserved mode used or saturation occurred in the last computation

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; fd=0, adc_rx_len=0, eth_tx_len=0, dev_cnt=0, err=0; internal mask, mode, bit index and count registers cleared.
- FSM states: IDLE, SCAN, CALC, TXC, DONE.
- IDLE, fs=1 sampled: latch cmd_kdev and cmd_mode, clear the count, index=0, go to SCAN. Inputs are not sampled again until the next IDLE.
- SCAN: each cycle, add mask[index] to the count and increment index. After the cycle that processes index N_DEV-1, go to CALC. SCAN lasts exactly N_DEV cycles.
- CALC: compute the payload, P = count*RX_PER_DEV, in internal width >= TX_W+2.
  - adc_rx_len = P+RX_HEAD. If this exceeds 2^RX_W-1, output all-ones and set the sat flag.
  - dev_cnt = count.
  - Go to TXC.
- TXC: compute eff_mode = (mode==3) ? 2 : mode.
  - eth_tx_len = (P << eff_mode) + TX_HEAD. If this exceeds 2^TX_W-1, output all-ones and set the sat flag.
  - err = sat | (mode==3).
  - Go to DONE.
- DONE: fd=1. Stay in DONE while fs=1. When fs=0 is sampled, set fd=0 and go to IDLE.
  - If fs was already low on entry, fd is high for exactly 1 cycle.
- Latency: the fs-sampling edge is edge 0, and fd rises after edge N_DEV+2. With the defaults, fd is high 10 edges after sampling.
- Output hold:
  - adc_rx_len and dev_cnt change only on the CALC edge.
  - eth_tx_len and err change only on the TXC edge.
  - All four outputs hold their values through DONE and IDLE until the next computation.
  - Consumers read them only while fd=1.
- fs dropping during SCAN/CALC/TXC has no effect: the computation completes and fd still asserts in DONE.
- Changes to cmd_kdev or cmd_mode after the latch edge are ignored.
- A new request requires fs low for at least one cycle, seen in DONE, and then fs high in IDLE. Holding fs high continuously gives exactly one computation.
- Zero devices: count=0, adc_rx_len=RX_HEAD, eth_tx_len=TX_HEAD, err=0 unless mode==3.
- Reset asserted mid-operation: immediate return to the reset values. No fd is produced for the aborted request.

Test Plan:
- Defaults, cmd_kdev=8'hFF, mode=0, fs held high -> after 10 edges fd=1, dev_cnt=8, adc_rx_len=772, eth_tx_len=784, err=0. fd stays 1 until fs=0, then drops the next cycle.
- cmd_kdev=8'h05, mode=1 -> dev_cnt=2, adc_rx_len=196, eth_tx_len=400, err=0. Then with cmd_kdev=8'h00, mode=0 -> adc_rx_len=4, eth_tx_len=16, dev_cnt=0.
- cmd_kdev=8'hFF, mode=2 -> eth_tx_len=3088, err=0. Rerun with TX_W=11 -> eth_tx_len=2047, err=1, adc_rx_len=772.
- cmd_kdev=8'h0F, mode=3 -> treated as mode 2: dev_cnt=4, adc_rx_len=388, eth_tx_len=1552, err=1.
- 1-cycle fs pulse with cmd_kdev changed to 8'h00 during SCAN -> result uses the latched mask (e.g. 8'h03 gives dev_cnt=2, adc_rx_len=196), and fd is high for exactly 1 cycle.
- rst_n low for 1 cycle at SCAN index 4 -> all outputs 0 asynchronously, state IDLE, no fd. A subsequent fs gives correct results with full latency.
